// File: rtl/ysyx_23060236_csr_exec_if.sv
// Bundled IDU/CSR-file/WBU signals of the CSR execution unit.
// 'master' is the execution unit; 'slave' is the environment (IDU, CSR file and WBU together).
interface ysyx_23060236_csr_exec_if #(
   parameter int unsigned Xlen  = 32,
   parameter int unsigned AddrW = 12
);
   // IDU -> unit
   logic             in_valid;
   logic             in_ready;
   logic             in_csr;
   logic             in_ecall;
   logic             in_mret;
   logic [2:0]       in_funct3;
   logic [AddrW-1:0] in_addr;
   logic [4:0]       in_rs1_idx;
   logic [Xlen-1:0]  in_rs1_data;
   logic [4:0]       in_rd;
   logic [Xlen-1:0]  in_pc;

   // unit <-> CSR file
   logic [AddrW-1:0] csr_imm;
   logic [Xlen-1:0]  csr_wdata;
   logic [Xlen-1:0]  csr_rdata;
   logic             csr_enable;
   logic             csr_ecall;
   logic             csr_mret;
   logic [Xlen-1:0]  csr_epc;
   logic [Xlen-1:0]  csr_jump;
   logic             csr_jump_en;
   logic             csr_valid;

   // unit -> WBU
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_rd;
   logic [Xlen-1:0]  out_wdata;
   logic             out_wen;
   logic             out_redirect;
   logic [Xlen-1:0]  out_redirect_pc;

   modport master (
      input  in_valid, in_csr, in_ecall, in_mret, in_funct3, in_addr, in_rs1_idx, in_rs1_data,
      input  in_rd, in_pc,
      output in_ready,
      output csr_imm, csr_wdata, csr_enable, csr_ecall, csr_mret, csr_epc, csr_valid,
      input  csr_rdata, csr_jump, csr_jump_en,
      output out_valid, out_rd, out_wdata, out_wen, out_redirect, out_redirect_pc,
      input  out_ready
   );

   modport slave (
      output in_valid, in_csr, in_ecall, in_mret, in_funct3, in_addr, in_rs1_idx, in_rs1_data,
      output in_rd, in_pc,
      input  in_ready,
      input  csr_imm, csr_wdata, csr_enable, csr_ecall, csr_mret, csr_epc, csr_valid,
      output csr_rdata, csr_jump, csr_jump_en,
      input  out_valid, out_rd, out_wdata, out_wen, out_redirect, out_redirect_pc,
      output out_ready
   );
endinterface

// File: rtl/ysyx_23060236_csr_exec.sv
// CSR execution unit: runs one Zicsr/ECALL/MRET op at a time through IDLE->READ->COMMIT->RESP,
// issuing a single-cycle commit strobe to the CSR file and returning rd/redirect to WBU.
module ysyx_23060236_csr_exec #(
   parameter int unsigned Xlen  = 32,
   parameter int unsigned AddrW = 12
) (
   input logic                       clock,
   input logic                       reset,
   ysyx_23060236_csr_exec_if.master  bus_io
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRead   = 2'd1,
      StCommit = 2'd2,
      StResp   = 2'd3
   } state_e;

   state_e           state_q, state_d;

   logic             csr_q, csr_d;
   logic             ecall_q, ecall_d;
   logic             mret_q, mret_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [4:0]       rs1_idx_q, rs1_idx_d;
   logic [Xlen-1:0]  rs1_data_q, rs1_data_d;
   logic [4:0]       rd_q, rd_d;
   logic [Xlen-1:0]  pc_q, pc_d;

   logic [Xlen-1:0]  old_q, old_d;
   logic [Xlen-1:0]  new_q, new_d;
   logic             wr_q, wr_d;
   logic             wen_q, wen_d;
   logic             redirect_q, redirect_d;
   logic [Xlen-1:0]  redirect_pc_q, redirect_pc_d;

   // Op priority when several flags are set: ecall > mret > csr.
   logic             is_ecall, is_mret, is_csr;
   logic             legal;
   logic [Xlen-1:0]  src;
   logic [Xlen-1:0]  new_val;

   assign is_ecall = ecall_q;
   assign is_mret  = mret_q & ~ecall_q;
   assign is_csr   = csr_q & ~ecall_q & ~mret_q;

   // funct3[2] selects the zero-extended zimm field instead of rs1 data.
   assign src = funct3_q[2] ? {{(Xlen-5){1'b0}}, rs1_idx_q} : rs1_data_q;

   always_comb begin
      legal   = 1'b1;
      new_val = old_d;
      case (funct3_q[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = old_d | src;
         2'b11:   new_val = old_d & ~src;
         default: begin
            new_val = old_d;
            legal   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         csr_q         <= 1'b0;
         ecall_q       <= 1'b0;
         mret_q        <= 1'b0;
         funct3_q      <= '0;
         addr_q        <= '0;
         rs1_idx_q     <= '0;
         rs1_data_q    <= '0;
         rd_q          <= '0;
         pc_q          <= '0;
         old_q         <= '0;
         new_q         <= '0;
         wr_q          <= 1'b0;
         wen_q         <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         csr_q         <= csr_d;
         ecall_q       <= ecall_d;
         mret_q        <= mret_d;
         funct3_q      <= funct3_d;
         addr_q        <= addr_d;
         rs1_idx_q     <= rs1_idx_d;
         rs1_data_q    <= rs1_data_d;
         rd_q          <= rd_d;
         pc_q          <= pc_d;
         old_q         <= old_d;
         new_q         <= new_d;
         wr_q          <= wr_d;
         wen_q         <= wen_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      csr_d         = csr_q;
      ecall_d       = ecall_q;
      mret_d        = mret_q;
      funct3_d      = funct3_q;
      addr_d        = addr_q;
      rs1_idx_d     = rs1_idx_q;
      rs1_data_d    = rs1_data_q;
      rd_d          = rd_q;
      pc_d          = pc_q;
      old_d         = old_q;
      new_d         = new_q;
      wr_d          = wr_q;
      wen_d         = wen_q;
      redirect_d    = redirect_q;
      redirect_pc_d = redirect_pc_q;

      case (state_q)
         StIdle: begin
            if (bus_io.in_valid) begin
               csr_d      = bus_io.in_csr;
               ecall_d    = bus_io.in_ecall;
               mret_d     = bus_io.in_mret;
               funct3_d   = bus_io.in_funct3;
               addr_d     = bus_io.in_addr;
               rs1_idx_d  = bus_io.in_rs1_idx;
               rs1_data_d = bus_io.in_rs1_data;
               rd_d       = bus_io.in_rd;
               pc_d       = bus_io.in_pc;
               state_d    = StRead;
            end
         end
         StRead: begin
            old_d   = bus_io.csr_rdata;
            new_d   = new_val;
            // Set/clear with rs1/zimm == 0 must not write (no side effects on read-only use).
            wr_d    = is_csr & legal & ((funct3_q[1:0] == 2'b01) | (rs1_idx_q != 5'd0));
            wen_d   = is_csr & legal & (rd_q != 5'd0);
            state_d = StCommit;
         end
         StCommit: begin
            redirect_d    = (is_ecall | is_mret) & bus_io.csr_jump_en;
            redirect_pc_d = redirect_d ? bus_io.csr_jump : '0;
            state_d       = StResp;
         end
         StResp: begin
            if (bus_io.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   logic in_commit, in_resp;

   assign in_commit = (state_q == StCommit);
   assign in_resp   = (state_q == StResp);

   always_comb begin
      bus_io.in_ready        = (state_q == StIdle);
      bus_io.csr_imm         = addr_q;
      bus_io.csr_wdata       = new_q;
      bus_io.csr_valid       = in_commit;
      bus_io.csr_enable      = in_commit & wr_q;
      bus_io.csr_ecall       = in_commit & is_ecall;
      bus_io.csr_mret        = in_commit & is_mret;
      bus_io.csr_epc         = pc_q;
      bus_io.out_valid       = in_resp;
      bus_io.out_rd          = rd_q;
      bus_io.out_wdata       = old_q;
      bus_io.out_wen         = in_resp & wen_q;
      bus_io.out_redirect    = in_resp & redirect_q;
      bus_io.out_redirect_pc = redirect_pc_q;
   end

endmodule

// File: tb/tb_ysyx_23060236_csr_exec.sv
// Directed bench for the CSR execution unit with a small behavioural CSR file around it.
module tb_ysyx_23060236_csr_exec;

   logic clock;
   logic reset;

   ysyx_23060236_csr_exec_if #(.Xlen(32), .AddrW(12)) bus ();

   ysyx_23060236_csr_exec #(.Xlen(32), .AddrW(12)) dut (
      .clock  (clock),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int commits = 0;

   logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
   logic        cap_enable, cap_ecall, cap_mret;
   logic [31:0] cap_wdata, cap_epc;
   logic [11:0] cap_imm;

   // Environment CSR file: combinational read, trap target, commit on csr_valid.
   always_comb begin
      case (bus.csr_imm)
         12'h300: bus.csr_rdata = mstatus_q;
         12'h305: bus.csr_rdata = mtvec_q;
         12'h341: bus.csr_rdata = mepc_q;
         12'h342: bus.csr_rdata = mcause_q;
         12'hF12: bus.csr_rdata = 32'h2306_0236;
         default: bus.csr_rdata = 32'h0;
      endcase
      bus.csr_jump    = bus.csr_ecall ? mtvec_q : (bus.csr_mret ? mepc_q : 32'h0);
      bus.csr_jump_en = bus.csr_ecall | bus.csr_mret;
   end

   always @(posedge clock) begin
      if (reset) begin
         mstatus_q <= 32'h0000_1800;
         mtvec_q   <= 32'h8000_0000;
         mepc_q    <= 32'h0;
         mcause_q  <= 32'h0;
      end else if (bus.csr_valid) begin
         commits    <= commits + 1;
         cap_enable <= bus.csr_enable;
         cap_ecall  <= bus.csr_ecall;
         cap_mret   <= bus.csr_mret;
         cap_wdata  <= bus.csr_wdata;
         cap_epc    <= bus.csr_epc;
         cap_imm    <= bus.csr_imm;
         if (bus.csr_ecall) begin
            mepc_q   <= bus.csr_epc;
            mcause_q <= 32'd11;
         end else if (bus.csr_enable) begin
            case (bus.csr_imm)
               12'h300: mstatus_q <= bus.csr_wdata;
               12'h305: mtvec_q   <= bus.csr_wdata;
               12'h341: mepc_q    <= bus.csr_wdata;
               12'h342: mcause_q  <= bus.csr_wdata;
               default: ;
            endcase
         end
      end
   end

   // Issue one op and wait (bounded) until out_valid; lat/cn are the cycles after acceptance.
   task automatic run_op(input logic c, input logic e, input logic m, input logic [2:0] f3,
                         input logic [11:0] a, input logic [4:0] idx, input logic [31:0] d,
                         input logic [4:0] rd, input logic [31:0] pc,
                         output int lat, output int cn);
      bit got;
      @(negedge clock);
      bus.in_csr = c; bus.in_ecall = e; bus.in_mret = m; bus.in_funct3 = f3;
      bus.in_addr = a; bus.in_rs1_idx = idx; bus.in_rs1_data = d; bus.in_rd = rd;
      bus.in_pc = pc; bus.in_valid = 1'b1;
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
      lat = 0; cn = 0; got = 1'b0;
      for (int i = 1; i <= 10 && !got; i++) begin
         @(negedge clock);
         if (bus.csr_valid) cn = i;
         if (bus.out_valid) begin
            lat = i;
            got = 1'b1;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL run_op_timeout out_valid got 0 want 1 within 10 cycles");
      end
   endtask

   task automatic retire();
      @(negedge clock);
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1 bus.out_ready = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL retire out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
      checks++;
      if ({bus.csr_valid, bus.csr_enable, bus.csr_ecall, bus.csr_mret, bus.out_valid,
           bus.out_wen, bus.out_redirect} !== 7'b0) begin
         errors++; $display("FAIL reset_strobes got %b%b%b%b%b%b%b want 0000000", bus.csr_valid,
            bus.csr_enable, bus.csr_ecall, bus.csr_mret, bus.out_valid, bus.out_wen,
            bus.out_redirect);
      end
      checks++;
      if ({bus.csr_wdata, bus.csr_epc, bus.out_wdata, bus.out_redirect_pc} !== 128'h0) begin
         errors++; $display("FAIL reset_data got %h %h %h %h want 0", bus.csr_wdata, bus.csr_epc,
            bus.out_wdata, bus.out_redirect_pc);
      end
   endtask

   task automatic test_csrrw();
      int lat, cn;
      run_op(1, 0, 0, 3'd1, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'h8000_0000, lat, cn);
      checks++;
      if (lat != 3 || cn != 2) begin
         errors++; $display("FAIL rw_latency got out %0d commit %0d want 3 2", lat, cn);
      end
      checks++;
      if (cap_enable !== 1'b1 || cap_wdata !== 32'h8000_0100 || cap_imm !== 12'h305) begin
         errors++; $display("FAIL rw_commit got en %b wdata %h imm %h want 1 80000100 305",
            cap_enable, cap_wdata, cap_imm);
      end
      checks++;
      if (bus.out_wdata !== 32'h8000_0000 || bus.out_wen !== 1'b1 || bus.out_rd !== 5'd5 ||
          bus.out_redirect !== 1'b0) begin
         errors++; $display("FAIL rw_resp got wdata %h wen %b rd %0d redir %b want 80000000 1 5 0",
            bus.out_wdata, bus.out_wen, bus.out_rd, bus.out_redirect);
      end
      retire();
      run_op(1, 0, 0, 3'd1, 12'h305, 5'd2, 32'h8000_0200, 5'd0, 32'h0, lat, cn);
      checks++;
      if (bus.out_wen !== 1'b0 || bus.out_wdata !== 32'h8000_0100) begin
         errors++; $display("FAIL rw_rd0 got wen %b wdata %h want 0 80000100",
            bus.out_wen, bus.out_wdata);
      end
      retire();
   endtask

   task automatic test_set_clear_reg();
      int lat, cn, c0;
      c0 = commits;
      run_op(1, 0, 0, 3'd2, 12'h300, 5'd0, 32'h0000_00FF, 5'd6, 32'h0, lat, cn);
      checks++;
      if (cap_enable !== 1'b0 || commits != c0 + 1) begin
         errors++; $display("FAIL rs_x0 got en %b commits %0d want 0 %0d", cap_enable, commits,
            c0 + 1);
      end
      checks++;
      if (bus.out_wdata !== 32'h0000_1800 || bus.out_wen !== 1'b1) begin
         errors++; $display("FAIL rs_x0_resp got %h wen %b want 00001800 1", bus.out_wdata,
            bus.out_wen);
      end
      retire();
      run_op(1, 0, 0, 3'd3, 12'h300, 5'd2, 32'h0000_0800, 5'd7, 32'h0, lat, cn);
      checks++;
      if (cap_enable !== 1'b1 || cap_wdata !== 32'h0000_1000 || bus.out_wdata !== 32'h0000_1800)
      begin
         errors++; $display("FAIL rc_reg got en %b wdata %h old %h want 1 00001000 00001800",
            cap_enable, cap_wdata, bus.out_wdata);
      end
      retire();
   endtask

   task automatic test_imm();
      logic [2:0]  f3 [4]   = '{3'd5, 3'd7, 3'd5, 3'd6};
      logic [4:0]  zimm [4] = '{5'h0B, 5'h03, 5'h0B, 5'h10};
      logic [31:0] expw [4] = '{32'h0B, 32'h08, 32'h0B, 32'h1B};
      logic [31:0] expo [4] = '{32'h00, 32'h0B, 32'h08, 32'h0B};
      int lat, cn;
      for (int i = 0; i < 4; i++) begin
         run_op(1, 0, 0, f3[i], 12'h342, zimm[i], 32'hFFFF_FFFF, 5'd8, 32'h0, lat, cn);
         checks++;
         if (cap_enable !== 1'b1 || cap_wdata !== expw[i] || bus.out_wdata !== expo[i]) begin
            errors++; $display("FAIL imm_%0d got en %b wdata %h old %h want 1 %h %h", i,
               cap_enable, cap_wdata, bus.out_wdata, expw[i], expo[i]);
         end
         retire();
      end
   endtask

   task automatic test_ecall_mret();
      int lat, cn;
      run_op(0, 1, 0, 3'd0, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0040, lat, cn);
      checks++;
      if (cap_ecall !== 1'b1 || cap_mret !== 1'b0 || cap_enable !== 1'b0 ||
          cap_epc !== 32'h8000_0040) begin
         errors++; $display("FAIL ecall_commit got ecall %b mret %b en %b epc %h want 1 0 0 80000040",
            cap_ecall, cap_mret, cap_enable, cap_epc);
      end
      checks++;
      if (bus.out_redirect !== 1'b1 || bus.out_redirect_pc !== 32'h8000_0200 ||
          bus.out_wen !== 1'b0) begin
         errors++; $display("FAIL ecall_resp got redir %b pc %h wen %b want 1 80000200 0",
            bus.out_redirect, bus.out_redirect_pc, bus.out_wen);
      end
      retire();
      run_op(0, 0, 1, 3'd0, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0300, lat, cn);
      checks++;
      if (cap_mret !== 1'b1 || cap_ecall !== 1'b0 || bus.out_redirect !== 1'b1 ||
          bus.out_redirect_pc !== 32'h8000_0040) begin
         errors++; $display("FAIL mret got mret %b ecall %b redir %b pc %h want 1 0 1 80000040",
            cap_mret, cap_ecall, bus.out_redirect, bus.out_redirect_pc);
      end
      retire();
   endtask

   task automatic test_priority_illegal();
      int lat, cn;
      run_op(1, 1, 1, 3'd1, 12'h305, 5'd1, 32'h0000_DEAD, 5'd9, 32'h8000_0080, lat, cn);
      checks++;
      if (cap_ecall !== 1'b1 || cap_mret !== 1'b0 || cap_enable !== 1'b0 || bus.out_wen !== 1'b0
          || bus.out_redirect_pc !== 32'h8000_0200) begin
         errors++; $display("FAIL prio got ecall %b mret %b en %b wen %b pc %h want 1 0 0 0 80000200",
            cap_ecall, cap_mret, cap_enable, bus.out_wen, bus.out_redirect_pc);
      end
      retire();
      run_op(0, 0, 0, 3'd1, 12'h305, 5'd1, 32'h0000_DEAD, 5'd9, 32'h0, lat, cn);
      checks++;
      if (cap_enable !== 1'b0 || cap_ecall !== 1'b0 || bus.out_wen !== 1'b0 ||
          bus.out_redirect !== 1'b0) begin
         errors++; $display("FAIL noop got en %b ecall %b wen %b redir %b want 0 0 0 0",
            cap_enable, cap_ecall, bus.out_wen, bus.out_redirect);
      end
      retire();
      run_op(1, 0, 0, 3'd4, 12'h305, 5'd1, 32'h0000_DEAD, 5'd10, 32'h0, lat, cn);
      checks++;
      if (cap_enable !== 1'b0 || bus.out_wen !== 1'b0) begin
         errors++; $display("FAIL illegal got en %b wen %b want 0 0", cap_enable, bus.out_wen);
      end
      retire();
      run_op(1, 0, 0, 3'd1, 12'hF12, 5'd1, 32'h0000_0005, 5'd11, 32'h0, lat, cn);
      checks++;
      if (cap_enable !== 1'b1 || bus.out_wdata !== 32'h2306_0236 || bus.out_wen !== 1'b1) begin
         errors++; $display("FAIL readonly got en %b old %h wen %b want 1 23060236 1",
            cap_enable, bus.out_wdata, bus.out_wen);
      end
      retire();
   endtask

   task automatic test_backpressure();
      int lat, cn, c0;
      run_op(1, 0, 0, 3'd2, 12'h305, 5'd0, 32'h0, 5'd12, 32'h0, lat, cn);
      c0 = commits;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_wdata !== 32'h8000_0200 ||
             bus.out_rd !== 5'd12 || commits != c0) begin
            errors++; $display("FAIL hold_%0d got vld %b rdy %b old %h rd %0d commits %0d", i,
               bus.out_valid, bus.in_ready, bus.out_wdata, bus.out_rd, commits);
         end
      end
      retire();
   endtask

   task automatic test_reset_in_read();
      int c0;
      c0 = commits;
      @(negedge clock);
      bus.in_csr = 1; bus.in_ecall = 0; bus.in_mret = 0; bus.in_funct3 = 3'd1;
      bus.in_addr = 12'h305; bus.in_rs1_idx = 5'd1; bus.in_rs1_data = 32'h1234_5678;
      bus.in_rd = 5'd13; bus.in_valid = 1'b1;
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.csr_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_read got rdy %b cvld %b ovld %b want 1 0 0", bus.in_ready,
            bus.csr_valid, bus.out_valid);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (commits != c0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_read_nocommit got commits %0d ovld %b want %0d 0", commits,
            bus.out_valid, c0);
      end
   endtask

   initial begin
      bus.in_valid = 0; bus.in_csr = 0; bus.in_ecall = 0; bus.in_mret = 0; bus.in_funct3 = 0;
      bus.in_addr = 0; bus.in_rs1_idx = 0; bus.in_rs1_data = 0; bus.in_rd = 0; bus.in_pc = 0;
      bus.out_ready = 0;
      test_reset();
      test_csrrw();
      test_set_clear_reg();
      test_imm();
      test_ecall_mret();
      test_priority_illegal();
      test_backpressure();
      test_reset_in_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
